// File: rtl/uart_stream_ctrl_if.sv
// Bundles the UART-core, stream and status signals of uart_stream_ctrl.
// slave = the controller itself, master = the surrounding system / bench.
interface uart_stream_ctrl_if #(
  parameter int DATA_W = 9,
  parameter int ERR_W  = 3,
  parameter int DEPTH  = 16,
  parameter int AXI_W  = 32
) ();
  localparam int LW = $clog2(DEPTH) + 1;

  logic              fifo_en;
  logic              flush;
  logic [DATA_W-1:0] rx_data;
  logic [ERR_W-1:0]  rx_error;
  logic              rx_done;
  logic              rx_ready;
  logic              tx_idle;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              rx_valid_axi;
  logic              rx_ready_axi;
  logic [AXI_W-1:0]  rx_data_axi;
  logic              tx_valid_axi;
  logic              tx_ready_axi;
  logic [AXI_W-1:0]  tx_data_axi;
  logic [LW-1:0]     rx_level;
  logic [LW-1:0]     tx_level;
  logic              rx_almost_full;
  logic              tx_almost_full;
  logic              rx_fifo_empty;
  logic              tx_fifo_empty;
  logic              rx_fifo_full;
  logic              tx_fifo_full;
  logic              rx_ovf;

  modport slave (
    input  fifo_en, flush, rx_data, rx_error, rx_done, tx_idle,
           rx_ready_axi, tx_valid_axi, tx_data_axi,
    output rx_ready, tx_start, tx_data, rx_valid_axi, rx_data_axi, tx_ready_axi,
           rx_level, tx_level, rx_almost_full, tx_almost_full,
           rx_fifo_empty, tx_fifo_empty, rx_fifo_full, tx_fifo_full, rx_ovf
  );

  modport master (
    output fifo_en, flush, rx_data, rx_error, rx_done, tx_idle,
           rx_ready_axi, tx_valid_axi, tx_data_axi,
    input  rx_ready, tx_start, tx_data, rx_valid_axi, rx_data_axi, tx_ready_axi,
           rx_level, tx_level, rx_almost_full, tx_almost_full,
           rx_fifo_empty, tx_fifo_empty, rx_fifo_full, tx_fifo_full, rx_ovf
  );
endinterface

// File: rtl/uart_stream_ctrl.sv
// UART <-> stream bridge: FWFT RX/TX FIFOs (or bypass) plus TX launch FSM; UART_STREAM_CTRL_ERR_DROP_EN drops errored RX frames.
// RX head/TX launch are combinational off registered state; backpressure via rx_ready / tx_ready_axi, RX overflow is sticky.
module uart_stream_ctrl #(
  parameter int DATA_W    = 9,
  parameter int ERR_W     = 3,
  parameter int DEPTH     = 16,
  parameter int AXI_W     = 32,
  parameter int AF_MARGIN = 2
) (
  input logic               clk,
  input logic               rst_n,
  uart_stream_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = DATA_W + ERR_W;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(DEPTH - AF_MARGIN);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_IDLE} state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_wait_cnt, w_wait_cnt_nxt;
  logic              r_fifo_en, r_live, r_rx_ovf;
  logic [RW-1:0]     r_rx_mem [DEPTH];
  logic [DATA_W-1:0] r_tx_mem [DEPTH];
  logic [AW-1:0]     r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
  logic [LW-1:0]     r_rx_lvl, r_tx_lvl;
  logic [DATA_W-1:0] r_tx_data;

  logic              w_clr, w_rx_ok, w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
  logic              w_rx_push, w_rx_pop, w_tx_push, w_tx_pop, w_src_vld, w_launch;
  logic [DATA_W-1:0] w_src_dat;
  logic [RW-1:0]     w_rx_word;
  logic              w_unused;

  // Flush or a mode switch empties both FIFOs; that cycle performs no push/pop/launch.
  assign w_clr = bus.flush | (bus.fifo_en != r_fifo_en);
`ifdef UART_STREAM_CTRL_ERR_DROP_EN
  assign w_rx_ok = (bus.rx_error == '0);
`else
  assign w_rx_ok = 1'b1;
`endif
  assign w_rx_word  = {bus.rx_error, bus.rx_data};
  assign w_rx_full  = (r_rx_lvl == FULL_LVL);
  assign w_rx_empty = (r_rx_lvl == '0);
  assign w_tx_full  = (r_tx_lvl == FULL_LVL);
  assign w_tx_empty = (r_tx_lvl == '0);
  assign w_unused   = ^bus.tx_data_axi[AXI_W-1:DATA_W];

  assign w_rx_pop  = bus.fifo_en & ~w_rx_empty & bus.rx_ready_axi & ~w_clr;
  assign w_rx_push = bus.fifo_en & bus.rx_done & w_rx_ok & (~w_rx_full | w_rx_pop) & ~w_clr;
  assign w_tx_push = bus.fifo_en & bus.tx_valid_axi & ~w_tx_full & ~w_clr;

  // In bypass the stream beat is the launch source directly.
  assign w_src_vld = bus.fifo_en ? ~w_tx_empty : bus.tx_valid_axi;
  assign w_src_dat = bus.fifo_en ? r_tx_mem[r_tx_rp] : bus.tx_data_axi[DATA_W-1:0];
  assign w_launch  = r_live & (r_state == IDLE) & bus.tx_idle & w_src_vld & ~w_clr;
  assign w_tx_pop  = w_launch & bus.fifo_en;

  assign bus.rx_ready     = bus.fifo_en ? ~w_rx_full : bus.rx_ready_axi;
  assign bus.rx_valid_axi = bus.fifo_en ? ~w_rx_empty : (bus.rx_done & w_rx_ok);
  assign bus.rx_data_axi  = AXI_W'(bus.fifo_en ? r_rx_mem[r_rx_rp] : w_rx_word);
  assign bus.tx_ready_axi = bus.fifo_en ? ~w_tx_full
                                        : (r_live & (r_state == IDLE) & bus.tx_idle & ~w_clr);
  assign bus.tx_start     = w_launch;
  assign bus.tx_data      = w_launch ? w_src_dat : r_tx_data;

  assign bus.rx_level       = r_rx_lvl;
  assign bus.tx_level       = r_tx_lvl;
  assign bus.rx_fifo_full   = w_rx_full;
  assign bus.tx_fifo_full   = w_tx_full;
  assign bus.rx_fifo_empty  = w_rx_empty;
  assign bus.tx_fifo_empty  = w_tx_empty;
  assign bus.rx_almost_full = (r_rx_lvl >= AF_LVL);
  assign bus.tx_almost_full = (r_tx_lvl >= AF_LVL);
  assign bus.rx_ovf         = r_rx_ovf;

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp] <= w_rx_word;
    if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.tx_data_axi[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo_en <= 1'b1;
      r_live    <= 1'b0;
      r_rx_ovf  <= 1'b0;
      r_rx_wp   <= '0;
      r_rx_rp   <= '0;
      r_tx_wp   <= '0;
      r_tx_rp   <= '0;
      r_rx_lvl  <= '0;
      r_tx_lvl  <= '0;
    end else begin
      r_fifo_en <= bus.fifo_en;
      r_live    <= 1'b1;
      if (w_clr) begin
        r_rx_ovf <= 1'b0;
        r_rx_wp  <= '0;
        r_rx_rp  <= '0;
        r_tx_wp  <= '0;
        r_tx_rp  <= '0;
        r_rx_lvl <= '0;
        r_tx_lvl <= '0;
      end else begin
        if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
        if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
        if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
        if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
        r_rx_lvl <= r_rx_lvl + LW'(w_rx_push) - LW'(w_rx_pop);
        r_tx_lvl <= r_tx_lvl + LW'(w_tx_push) - LW'(w_tx_pop);
        if (bus.fifo_en & bus.rx_done & w_rx_ok & w_rx_full & ~w_rx_pop) r_rx_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_launch) r_tx_data <= w_src_dat;
    end
  end

  // WAIT_BUSY gives the core 4 cycles to drop tx_idle before giving up on that launch.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      IDLE: begin
        if (w_launch) begin
          w_state_nxt    = WAIT_BUSY;
          w_wait_cnt_nxt = '0;
        end
      end
      WAIT_BUSY: begin
        if (!bus.tx_idle)            w_state_nxt    = WAIT_IDLE;
        else if (r_wait_cnt == 2'd3) w_state_nxt    = IDLE;
        else                         w_wait_cnt_nxt = r_wait_cnt + 2'd1;
      end
      WAIT_IDLE: begin
        if (bus.tx_idle) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule
